// File: rtl/control_fsm.sv
// Multicycle control FSM: decodes instr/PSR from the datapath and drives its
// enables/selects plus a memory request handshake guarded by a watchdog.
module control_fsm #(
  parameter int WIDTH       = 16,
  parameter int REGBITS     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   instr,
  input  logic [7:0]         PSROut,
  input  logic               memReady,
  output logic               memReq,
  output logic               memWrite,
  output logic               PCEN,
  output logic               PSREN,
  output logic               nextInstruction,
  output logic               regWrite,
  output logic               updateAddress,
  output logic               StoreReg,
  output logic               WriteData,
  output logic               ZeroExtend,
  output logic               PCinstruction,
  output logic               SrcB,
  output logic               shiftType,
  output logic               JmpEN,
  output logic               BranchEN,
  output logic               JALEN,
  output logic [REGBITS-1:0] ALUcond,
  output logic [1:0]         chooseResult,
  output logic               fault
);

  localparam int WDW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_LOAD, S_STORE,
    S_JAL, S_JCOND, S_BRANCH, S_PCINC, S_HALT
  } state_t;

  typedef struct packed {
    logic               memReq;
    logic               memWrite;
    logic               PCEN;
    logic               PSREN;
    logic               nextInstruction;
    logic               regWrite;
    logic               updateAddress;
    logic               StoreReg;
    logic               WriteData;
    logic               ZeroExtend;
    logic               PCinstruction;
    logic               SrcB;
    logic               shiftType;
    logic               JmpEN;
    logic               BranchEN;
    logic               JALEN;
    logic [REGBITS-1:0] ALUcond;
    logic [1:0]         chooseResult;
    logic               fault;
  } ctl_t;

  state_t             state, state_nxt;
  ctl_t               ctl;
  logic [WDW-1:0]     wd;
  logic [3:0]         opcode, ext, cond;
  logic [REGBITS-1:0] alu_op;
  logic               taken, mem_req_int, mem_wait, wd_expire;
  logic               unused_bits;

  assign opcode = instr[15:12];
  assign cond   = instr[11:8];
  assign ext    = instr[7:4];
  assign unused_bits = ^{PSROut[5:1], instr[3:0]};

  always_comb begin
    case (cond)
      4'b0000: taken = PSROut[6];
      4'b0001: taken = !PSROut[6];
      4'b0010: taken = PSROut[0];
      4'b0011: taken = !PSROut[0];
      4'b0110: taken = PSROut[7];
      4'b0111: taken = !PSROut[7];
      4'b1110: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Watchdog only runs while a request is outstanding in one state.
  assign mem_req_int = (state == S_FETCH) || (state == S_LOAD) || (state == S_STORE);
  assign mem_wait    = mem_req_int && !memReady;
  assign wd_expire   = mem_wait && (wd == WDW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || !mem_wait) wd <= '0;
      else                                 wd <= wd + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (memReady) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101,
          4'b1001, 4'b1011, 4'b1101, 4'b1000: state_nxt = S_EXEC;
          4'b0100: begin
            case (ext)
              4'b0000: state_nxt = S_LOAD;
              4'b0100: state_nxt = S_STORE;
              4'b1000: state_nxt = S_JAL;
              4'b1100: state_nxt = S_JCOND;
              default: state_nxt = S_PCINC;
            endcase
          end
          4'b1100: state_nxt = S_BRANCH;
          default: state_nxt = S_PCINC;
        endcase
      end
      S_EXEC:           state_nxt = S_PCINC;
      S_LOAD, S_STORE:  if (memReady) state_nxt = S_PCINC;
      S_JAL:            state_nxt = S_FETCH;
      S_JCOND, S_BRANCH: state_nxt = taken ? S_FETCH : S_PCINC;
      S_PCINC:          state_nxt = S_FETCH;
      S_HALT:           state_nxt = S_HALT;
      default:          state_nxt = S_FETCH;
    endcase
    if (wd_expire) state_nxt = S_HALT;
  end

  always_comb begin
    ctl    = '0;
    alu_op = (opcode == 4'b0000) ? ext : opcode;
    case (state)
      S_FETCH: begin
        ctl.memReq          = 1'b1;
        ctl.updateAddress   = 1'b1;
        ctl.nextInstruction = memReady;
      end
      S_EXEC: begin
        if (opcode == 4'b1000) begin
          ctl.chooseResult = 2'b00;
          ctl.shiftType    = instr[5];
          ctl.regWrite     = 1'b1;
          ctl.WriteData    = 1'b1;
        end else begin
          // Compare ops update flags only.
          ctl.chooseResult = 2'b01;
          ctl.PSREN        = 1'b1;
          ctl.SrcB         = (opcode == 4'b0000);
          ctl.ALUcond      = alu_op;
          ctl.ZeroExtend   = opcode inside {4'b0001, 4'b0010, 4'b0011};
          ctl.regWrite     = (alu_op != 4'b1011);
          ctl.WriteData    = (alu_op != 4'b1011);
        end
      end
      S_LOAD: begin
        ctl.memReq   = 1'b1;
        ctl.regWrite = memReady;
      end
      S_STORE: begin
        ctl.memReq   = 1'b1;
        ctl.memWrite = 1'b1;
        ctl.StoreReg = 1'b1;
      end
      S_JAL: begin
        ctl.regWrite     = 1'b1;
        ctl.chooseResult = 2'b11;
        ctl.JALEN        = 1'b1;
        ctl.PCEN         = 1'b1;
      end
      S_JCOND: begin
        ctl.JmpEN = taken;
        ctl.PCEN  = taken;
      end
      S_BRANCH: begin
        ctl.PCinstruction = taken;
        ctl.BranchEN      = taken;
        ctl.PCEN          = taken;
      end
      S_PCINC: begin
        ctl.PCinstruction = 1'b1;
        ctl.PCEN          = 1'b1;
      end
      S_HALT:  ctl.fault = 1'b1;
      default: ctl = '0;
    endcase
  end

  // Reset forces outputs low immediately, including a request mid-access.
  ctl_t ctl_q;
  assign ctl_q = reset ? ctl : '0;

  assign memReq          = ctl_q.memReq;
  assign memWrite        = ctl_q.memWrite;
  assign PCEN            = ctl_q.PCEN;
  assign PSREN           = ctl_q.PSREN;
  assign nextInstruction = ctl_q.nextInstruction;
  assign regWrite        = ctl_q.regWrite;
  assign updateAddress   = ctl_q.updateAddress;
  assign StoreReg        = ctl_q.StoreReg;
  assign WriteData       = ctl_q.WriteData;
  assign ZeroExtend      = ctl_q.ZeroExtend;
  assign PCinstruction   = ctl_q.PCinstruction;
  assign SrcB            = ctl_q.SrcB;
  assign shiftType       = ctl_q.shiftType;
  assign JmpEN           = ctl_q.JmpEN;
  assign BranchEN        = ctl_q.BranchEN;
  assign JALEN           = ctl_q.JALEN;
  assign ALUcond         = ctl_q.ALUcond;
  assign chooseResult    = ctl_q.chooseResult;
  assign fault           = ctl_q.fault;

endmodule
